// File: rtl/eth_parser_pkg.sv
// rtl/eth_parser_pkg.sv - Ethernet field types, frame constants and header byte selection
// ETH_TX_PAD_EN adds the PAD state used by minimum-payload padding.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  localparam int ETH_HDR_LEN     = 14;
  localparam int ETH_MIN_PAYLOAD = 46;

`ifdef ETH_TX_PAD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_PAD} tx_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} tx_state_t;
`endif

  // Byte 0 is dest_mac[47:40]; the header goes out most significant byte first.
  function automatic logic [7:0] hdr_byte(mac_addr_t dest, mac_addr_t src,
                                          ethertype_t etype, logic [3:0] idx);
    logic [111:0] frame_hdr;
    frame_hdr = {dest, src, etype} << (8 * idx);
    return frame_hdr[111:104];
  endfunction

endpackage

// File: rtl/eth_header_builder_if.sv
// rtl/eth_header_builder_if.sv - header request, payload-in and frame-out signal bundle
interface eth_header_builder_if;
  import eth_parser_pkg::*;

  logic       hdr_valid;
  logic       hdr_ready;
  mac_addr_t  dest_mac;
  mac_addr_t  src_mac;
  ethertype_t ethertype;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  logic       busy;

  modport master (
    output hdr_valid, dest_mac, src_mac, ethertype,
    output s_data, s_valid, s_last, m_ready,
    input  hdr_ready, s_ready, m_data, m_valid, m_last, busy
  );

  modport slave (
    input  hdr_valid, dest_mac, src_mac, ethertype,
    input  s_data, s_valid, s_last, m_ready,
    output hdr_ready, s_ready, m_data, m_valid, m_last, busy
  );

endinterface

// File: rtl/eth_header_builder.sv
// rtl/eth_header_builder.sv - prepends a 14-byte Ethernet header to a payload byte stream
// ETH_TX_PAD_EN pads short payloads with zero bytes up to ETH_MIN_PAYLOAD.
module eth_header_builder
  import eth_parser_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  eth_header_builder_if.slave bus
);

  tx_state_t  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  mac_addr_t  dest_q, dest_d;
  mac_addr_t  src_q, src_d;
  ethertype_t type_q, type_d;
  // Holds hdr_ready low until the first clock edge after reset release.
  logic       live_q;
`ifdef ETH_TX_PAD_EN
  logic [5:0] cnt_q, cnt_d;
  logic       min_reached;
  logic       pad_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dest_q  <= '0;
      src_q   <= '0;
      type_q  <= '0;
      live_q  <= 1'b0;
`ifdef ETH_TX_PAD_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      type_q  <= type_d;
      live_q  <= 1'b1;
`ifdef ETH_TX_PAD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dest_d        = dest_q;
    src_d         = src_q;
    type_d        = type_q;
    bus.hdr_ready = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_data    = 8'h00;
    bus.m_last    = 1'b0;
    bus.s_ready   = 1'b0;
`ifdef ETH_TX_PAD_EN
    cnt_d       = cnt_q;
    min_reached = (cnt_q >= 6'(ETH_MIN_PAYLOAD - 1));
    pad_last    = (cnt_q == 6'(ETH_MIN_PAYLOAD - 1));
`endif

    case (state_q)
      ST_IDLE: begin
        bus.hdr_ready = live_q;
        if (bus.hdr_valid && live_q) begin
          dest_d  = bus.dest_mac;
          src_d   = bus.src_mac;
          type_d  = bus.ethertype;
          idx_d   = '0;
          state_d = ST_HEADER;
`ifdef ETH_TX_PAD_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_HEADER: begin
        bus.m_valid = 1'b1;
        bus.m_data  = hdr_byte(dest_q, src_q, type_q, idx_q);
        if (bus.m_ready) begin
          if (idx_q == 4'(ETH_HDR_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        bus.m_valid = bus.s_valid;
        bus.m_data  = bus.s_data;
        bus.s_ready = bus.m_ready;
`ifdef ETH_TX_PAD_EN
        bus.m_last  = bus.s_last && min_reached;
        if (bus.s_valid && bus.m_ready) begin
          if (cnt_q != 6'(ETH_MIN_PAYLOAD))
            cnt_d = cnt_q + 6'd1;
          if (bus.s_last)
            state_d = min_reached ? ST_IDLE : ST_PAD;
        end
`else
        bus.m_last  = bus.s_last;
        if (bus.s_valid && bus.m_ready && bus.s_last)
          state_d = ST_IDLE;
`endif
      end

`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        bus.m_valid = 1'b1;
        bus.m_last  = pad_last;
        if (bus.m_ready) begin
          cnt_d = cnt_q + 6'd1;
          if (pad_last)
            state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    bus.busy = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_eth_header_builder.sv
// tb/tb_eth_header_builder.sv - frame vector table with byte scoreboard, plus reset corner sequences
module tb_eth_header_builder;
  import eth_parser_pkg::*;

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  eth_header_builder_if bus();

  eth_header_builder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          len;
    bit          toggle;
    bit          hold;
    bit          change;
    int          exp_len;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit toggle = 1'b0;
  bit done_flag = 1'b0;
  bit in_frame = 1'b0;
  bit rdy_chk = 1'b0;
  int frame_bytes = 0;
  int last_pos = 0;
  int hr_bad = 0;
  bit held_v = 1'b0;
  logic [7:0] held_d;
  logic held_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = toggle ? !bus.m_ready : 1'b1;
    end
  end

  // Scoreboard: every transferred output byte is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (rdy_chk) begin
        check("ready_after_last", bus.hdr_ready, 1);
        rdy_chk = 1'b0;
      end
      if (in_frame && bus.hdr_ready)
        hr_bad++;
      if (bus.m_valid) begin
        if (held_v) begin
          check("stall_data", bus.m_data, held_d);
          check("stall_last", bus.m_last, held_l);
        end
        if (bus.m_ready) begin
          held_v = 1'b0;
          frame_bytes++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", frame_bytes, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("byte_data[%0d]", frame_bytes), bus.m_data, mon_e.data);
            check($sformatf("byte_last[%0d]", frame_bytes), bus.m_last, mon_e.last);
            if (mon_e.last) begin
              last_pos  = frame_bytes;
              done_flag = 1'b1;
              in_frame  = 1'b0;
              rdy_chk   = 1'b1;
            end
          end
        end else begin
          held_v = 1'b1;
          held_d = bus.m_data;
          held_l = bus.m_last;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic send_frame(input vec_t v);
    logic [7:0]   pl [64];
    logic [111:0] hdr;
    int           i;
    int           budget;
    hdr = {v.dest, v.src, v.etype};
    for (int k = 0; k < ETH_HDR_LEN; k++)
      exp_q.push_back(exp_t'({hdr[111 - 8*k -: 8], 1'b0}));
    for (int k = 0; k < v.len; k++) begin
      pl[k] = 8'($urandom_range(0, 255));
      exp_q.push_back(exp_t'({pl[k], (k == v.len - 1) && (!PAD_ON || v.len >= ETH_MIN_PAYLOAD)}));
    end
    if (PAD_ON)
      for (int k = v.len; k < ETH_MIN_PAYLOAD; k++)
        exp_q.push_back(exp_t'({8'h00, k == ETH_MIN_PAYLOAD - 1}));
    done_flag   = 1'b0;
    frame_bytes = 0;
    last_pos    = 0;

    bus.dest_mac  = v.dest;
    bus.src_mac   = v.src;
    bus.ethertype = v.etype;
    bus.hdr_valid = 1'b1;
    budget = 200;
    while (!bus.hdr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("hdr_accept_in_time", budget > 0, 1);
    @(posedge clk);
    #1;
    in_frame = 1'b1;
    if (!v.hold) bus.hdr_valid = 1'b0;
    if (v.change) begin
      bus.dest_mac  = ~v.dest;
      bus.src_mac   = ~v.src;
      bus.ethertype = ~v.etype;
    end
    bus.s_data  = pl[0];
    bus.s_valid = 1'b1;
    bus.s_last  = (v.len == 1);
    @(negedge clk);
    check("first_byte_valid", bus.m_valid, 1);
    check("first_byte_data", bus.m_data, v.dest[47:40]);

    i = 0;
    budget = 2000;
    while (i < v.len && budget > 0) begin
      if (bus.s_ready) begin
        @(posedge clk);
        #1;
        i++;
        if (i < v.len) begin
          bus.s_data = pl[i];
          bus.s_last = (i == v.len - 1);
        end else begin
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
        end
      end
      @(negedge clk);
      budget--;
    end
    check("payload_in_time", i, v.len);

    budget = 2000;
    while (!done_flag && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("frame_done_in_time", done_flag, 1);
    check("m_last_position", last_pos, v.exp_len);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 60, 1'b0, 1'b0, 1'b0, 74};
    vecs[1] = '{48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0800, 60, 1'b1, 1'b0, 1'b0, 74};
    vecs[2] = '{48'h020406080A0C, 48'hA1B2C3D4E5F6, 16'h86DD, 10, 1'b0, 1'b0, 1'b1, PAD_ON ? 60 : 24};
    vecs[3] = '{48'h3C3C3C3C3C3C, 48'hC3C3C3C3C3C3, 16'h0806, 46, 1'b0, 1'b0, 1'b0, 60};
    vecs[4] = '{48'h0123456789AB, 48'hCDEF01234567, 16'h0042, 1,  1'b1, 1'b0, 1'b0, PAD_ON ? 60 : 15};
    vecs[5] = '{48'h112233445566, 48'h778899AABBCC, 16'h88CC, 45, 1'b1, 1'b0, 1'b0, PAD_ON ? 60 : 59};
    vecs[6] = '{48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 20, 1'b0, 1'b1, 1'b0, PAD_ON ? 60 : 34};
    vecs[7] = '{48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h8100, 8,  1'b0, 1'b0, 1'b0, PAD_ON ? 60 : 22};

    bus.hdr_valid = 1'b0;
    bus.dest_mac  = '0;
    bus.src_mac   = '0;
    bus.ethertype = '0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;

    #2 rst_n = 1'b0;
    #10;
    check("rst_hdr_ready", bus.hdr_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.hdr_ready, 1);
    check("idle_not_busy", bus.busy, 0);
    mon_en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      toggle = vecs[k].toggle;
      send_frame(vecs[k]);
    end
    toggle = 1'b0;
    check("hdr_ready_low_in_frame", hr_bad, 0);

    // Reset pulse while header byte 7 is on the output.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    bus.dest_mac  = 48'h0A0B0C0D0E0F;
    bus.src_mac   = 48'h102030405060;
    bus.ethertype = 16'h86DD;
    bus.hdr_valid = 1'b1;
    @(negedge clk);
    check("midframe_hdr_ready", bus.hdr_ready, 1);
    @(posedge clk);
    #1;
    bus.hdr_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_reset_byte7", bus.m_data, 8'h20);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", bus.m_valid, 0);
    check("async_rst_m_data", bus.m_data, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_hdr_ready", bus.hdr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midframe_reset", bus.hdr_ready, 1);
    check("no_residual_valid", bus.m_valid, 0);
    exp_q.delete();
    in_frame = 1'b0;
    held_v   = 1'b0;
    rdy_chk  = 1'b0;
    mon_en   = 1'b1;
    send_frame(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
